// File: rtl/input_conditioner_if.sv
// Key, switch and busy inputs plus the conditioned pulses, level and switch copies
// exchanged between the front-end driver and the input conditioner.
interface input_conditioner_if #(
   parameter int SW_WIDTH = 8
);
   logic                Run_n;
   logic                Clear_n;
   logic [SW_WIDTH-1:0] Sw_Raw;
   logic                Mult_Busy;
   logic                Run_Pulse;
   logic                Clear_Pulse;
   logic                Clear_Level;
   logic [SW_WIDTH-1:0] Sw_Sync;
   logic [SW_WIDTH-1:0] Sw_Latched;

   modport master (
      output Run_n, Clear_n, Sw_Raw, Mult_Busy,
      input  Run_Pulse, Clear_Pulse, Clear_Level, Sw_Sync, Sw_Latched
   );

   modport slave (
      input  Run_n, Clear_n, Sw_Raw, Mult_Busy,
      output Run_Pulse, Clear_Pulse, Clear_Level, Sw_Sync, Sw_Latched
   );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the Run/Clear keys for the serial multiplier controller,
// emitting one-cycle press pulses, a Clear level and synchronised/latched operand switches.
module input_conditioner #(
   parameter int DB_CYCLES = 500000,
   parameter int SW_WIDTH  = 8
) (
   input logic                Clk,
   input logic                Reset,
   input_conditioner_if.slave bus
);
   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam int RUN = 0;
   localparam int CLR = 1;

   // Bit 1 of the encoding is the debounced level (PRESSED / RELEASE_WAIT).
   localparam logic [1:0] IDLE         = 2'b00;
   localparam logic [1:0] PRESS_WAIT   = 2'b01;
   localparam logic [1:0] PRESSED      = 2'b10;
   localparam logic [1:0] RELEASE_WAIT = 2'b11;

   logic [1:0]          key_p0;
   logic [1:0]          key_p1;
   logic [1:0]          s;
   logic [SW_WIDTH-1:0] sw_p0;
   logic [1:0]          state     [2];
   logic [1:0]          state_nxt [2];
   logic [CNT_W-1:0]    cnt       [2];
   logic [CNT_W-1:0]    cnt_nxt   [2];
   logic [1:0]          accept;

   // Stage p0/p1: two-flop synchronisers, keys idle released (1)
   always_ff @(posedge Clk) begin
      if (Reset) begin
         key_p0      <= 2'b11;
         key_p1      <= 2'b11;
         sw_p0       <= '0;
         bus.Sw_Sync <= '0;
      end else begin
         key_p0      <= {bus.Clear_n, bus.Run_n};
         key_p1      <= key_p0;
         sw_p0       <= bus.Sw_Raw;
         bus.Sw_Sync <= sw_p0;
      end
   end

   assign s = ~key_p1;

   always_comb begin
      accept = 2'b00;
      for (int k = 0; k < 2; k++) begin
         state_nxt[k] = state[k];
         cnt_nxt[k]   = cnt[k];
         case (state[k])
            IDLE: begin
               if (s[k]) begin
                  state_nxt[k] = PRESS_WAIT;
                  cnt_nxt[k]   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!s[k]) begin
                  state_nxt[k] = IDLE;
               end else if (cnt[k] == CNT_LAST) begin
                  state_nxt[k] = PRESSED;
                  accept[k]    = 1'b1;
               end else begin
                  cnt_nxt[k] = cnt[k] + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!s[k]) begin
                  state_nxt[k] = RELEASE_WAIT;
                  cnt_nxt[k]   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (s[k]) begin
                  state_nxt[k] = PRESSED;
               end else if (cnt[k] == CNT_LAST) begin
                  state_nxt[k] = IDLE;
               end else begin
                  cnt_nxt[k] = cnt[k] + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 0; k < 2; k++) begin
            state[k] <= IDLE;
            cnt[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            state[k] <= state_nxt[k];
            cnt[k]   <= cnt_nxt[k];
         end
      end
   end

   // Output stage: Clear beats Run on a shared accept edge; busy only gates Run
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.Run_Pulse   <= 1'b0;
         bus.Clear_Pulse <= 1'b0;
         bus.Clear_Level <= 1'b0;
         bus.Sw_Latched  <= '0;
      end else begin
         bus.Run_Pulse   <= accept[RUN] && !bus.Mult_Busy && !accept[CLR];
         bus.Clear_Pulse <= accept[CLR];
         bus.Clear_Level <= state_nxt[CLR][1];
         if (accept[CLR]) begin
            bus.Sw_Latched <= bus.Sw_Sync;
         end
      end
   end
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner at DB_CYCLES=4: table-driven key scenarios plus hand sequences
// for bounce, busy gating, switch latching and reset during debounce.
module tb_input_conditioner;
   logic Clk = 1'b0;
   logic Reset;
   int   errors = 0;
   int   checks = 0;

   input_conditioner_if #(.SW_WIDTH(8)) bus ();

   input_conditioner #(.DB_CYCLES(4), .SW_WIDTH(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit    run;
      bit    clr;
      bit    lvl;
      string name;
      int    t;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      string name;
      int    run_lo, run_hi;
      int    clr_lo, clr_hi;
      bit    busy;
      int    run_at, clr_at;
      int    lvl_rise, lvl_fall;
      int    len;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Push the expectation for the next edge, clock, then pop and compare.
   task automatic step(input bit run, input bit clr, input bit lvl, input string name, input int t);
      exp_t e;
      exp_q.push_back('{run, clr, lvl, name, t});
      @(posedge Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.Run_Pulse !== e.run || bus.Clear_Pulse !== e.clr || bus.Clear_Level !== e.lvl) begin
         errors++;
         $display("FAIL %s t=%0d: run/clr/lvl got %b%b%b expected %b%b%b", e.name, e.t,
                  bus.Run_Pulse, bus.Clear_Pulse, bus.Clear_Level, e.run, e.clr, e.lvl);
      end
   endtask

   task automatic do_reset();
      Reset         = 1'b1;
      bus.Run_n     = 1'b1;
      bus.Clear_n   = 1'b1;
      bus.Mult_Busy = 1'b0;
      step(0, 0, 0, "reset", 0);
      step(0, 0, 0, "reset", 1);
      check("reset_sw_sync", 32'(bus.Sw_Sync), 32'h0);
      check("reset_sw_latched", 32'(bus.Sw_Latched), 32'h0);
      Reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"clean_run",  0, 20, -1, -1, 1'b0,  6, -1, -1, -1, 30};
      vecs[1] = '{"late_run",   3, 12, -1, -1, 1'b0,  9, -1, -1, -1, 24};
      vecs[2] = '{"busy_run",   0, 20, -1, -1, 1'b1, -1, -1, -1, -1, 30};
      vecs[3] = '{"simul",      0, 20,  0, 20, 1'b0, -1,  6,  6, 26, 30};
      vecs[4] = '{"clear_only", -1, -1, 2, 10, 1'b0, -1,  8,  8, 16, 24};

      Reset       = 1'b1;
      bus.Sw_Raw  = 8'hFF;
      do_reset();

      foreach (vecs[i]) begin
         do_reset();
         for (int t = 0; t < vecs[i].len; t++) begin
            bus.Run_n     = !(t >= vecs[i].run_lo && t < vecs[i].run_hi);
            bus.Clear_n   = !(t >= vecs[i].clr_lo && t < vecs[i].clr_hi);
            bus.Mult_Busy = vecs[i].busy;
            step(t == vecs[i].run_at, t == vecs[i].clr_at,
                 (t >= vecs[i].lvl_rise && t < vecs[i].lvl_fall && vecs[i].lvl_rise >= 0),
                 vecs[i].name, t);
         end
      end

      // Bounce on Run, then a clean press must take the full debounce from IDLE
      do_reset();
      for (int t = 0; t < 25; t++) begin
         bus.Run_n = (t < 12) ? ((t / 2) % 2 == 1) : 1'b1;
         step(0, 0, 0, "bounce", t);
      end
      for (int t = 0; t < 12; t++) begin
         bus.Run_n = 1'b0;
         step(t == 6, 0, 0, "after_bounce", t);
      end

      // Busy press is consumed; the next press after release fires once
      do_reset();
      bus.Mult_Busy = 1'b1;
      for (int t = 0; t < 34; t++) begin
         if (t == 18) bus.Mult_Busy = 1'b0;
         bus.Run_n = !(t < 8 || t >= 18);
         step(t == 24, 0, 0, "busy_gate", t);
      end

      // Clear captures the switches; later switch changes do not disturb the latch
      do_reset();
      bus.Run_n  = 1'b1;
      bus.Sw_Raw = 8'hA5;
      for (int t = 0; t < 3; t++) step(0, 0, 0, "latch_idle", t);
      check("sw_sync_a5", 32'(bus.Sw_Sync), 32'hA5);
      for (int t = 0; t < 24; t++) begin
         bus.Clear_n = !(t < 12);
         if (t == 7) bus.Sw_Raw = 8'h3C;
         step(0, t == 6, (t >= 6 && t < 18), "clear_latch", t);
         if (t == 6) check("latched_at_accept", 32'(bus.Sw_Latched), 32'hA5);
         if (t == 7) check("sw_sync_lag", 32'(bus.Sw_Sync), 32'hA5);
         if (t == 8) check("sw_sync_new", 32'(bus.Sw_Sync), 32'h3C);
      end
      check("latched_held", 32'(bus.Sw_Latched), 32'hA5);

      // Reset lands on the would-be accept edge; held key re-debounces afterwards
      for (int t = 0; t < 20; t++) begin
         bus.Clear_n = 1'b0;
         Reset       = (t == 6);
         step(0, t == 13, t >= 13, "reset_mid", t);
         if (t == 6) begin
            check("reset_mid_latched", 32'(bus.Sw_Latched), 32'h0);
            check("reset_mid_sync", 32'(bus.Sw_Sync), 32'h0);
         end
         if (t == 13) check("reset_mid_relatch", 32'(bus.Sw_Latched), 32'h3C);
      end
      Reset = 1'b0;

      if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front end for the serial 8-bit multiplier controller.
- Synchronises and debounces the raw active-low Run and Clear keys.
- Produces single-cycle Run/Clear pulses, a debounced Clear level, and a synchronised, press-latched copy of the 8 operand switches (consumed by the controller's load-B state).
- All outputs are registered; the controller FSM connects directly.

Parameters:
DB_CYCLES, 500000, consecutive stable samples required to accept a key edge (10 ms at 50 MHz); legal range >= 2; counter width $clog2(DB_CYCLES)
SW_WIDTH, 8, operand switch width

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous active-high reset
Run_n  input  1  raw Run key, active-low, asynchronous to Clk
Clear_n  input  1  raw Reset/Load/Clear key, active-low, asynchronous to Clk
Sw_Raw  input  SW_WIDTH  raw slide switches, asynchronous
Mult_Busy  input  1  high while multiplier is in any add/shift/sub state
Run_Pulse  output  1  one-cycle pulse per accepted Run press
Clear_Pulse  output  1  one-cycle pulse per accepted Clear press
Clear_Level  output  1  debounced Clear key level (1 = pressed)
Sw_Sync  output  SW_WIDTH  2-flop synchronised switches
Sw_Latched  output  SW_WIDTH  Sw_Sync captured at each accepted Clear press

Behaviour:
- Synchronisers: 2 flops per key and per switch bit. On Reset, key flops load 1 (released) and switch flops load 0. The synchronised key s is the inverted second flop (1 = pressed).
- Reset values: Run_Pulse=0, Clear_Pulse=0, Clear_Level=0, Sw_Sync=0, Sw_Latched=0. Both key FSMs go to IDLE with counters at 0.
- Key FSM: one identical instance per key. States IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: s=0 -> IDLE (bounce rejected). Otherwise, cnt==DB_CYCLES-1 -> PRESSED and fire the accept event. Otherwise cnt++.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: s=1 -> PRESSED (no new event). Otherwise, cnt==DB_CYCLES-1 -> IDLE. Otherwise cnt++.
  - Level is 1 in PRESSED and RELEASE_WAIT.
- Latency: let edge 0 be the first Clk edge that samples the key low, held stable. The accept event is registered on edge DB_CYCLES+2, so the pulse is high exactly for the cycle after that edge. Clear_Level rises on the same edge and falls DB_CYCLES+2 edges after the first edge that samples the release.
- Pulse width is exactly 1 cycle. A held key never re-fires. One pulse per press/release cycle.
- Run gating:
  - If Mult_Busy=1 on the Run accept edge, Run_Pulse is suppressed. The press is consumed (FSM still enters PRESSED), not queued.
  - If Clear and Run accept on the same edge, Clear_Pulse fires and Run_Pulse is suppressed. Clear dominates.
- Clear_Pulse is never gated by Mult_Busy.
- Sw_Latched loads Sw_Sync on the Clear accept edge and holds otherwise. Sw_Sync follows Sw_Raw with a 2-edge lag.
- Reset mid-operation: the Reset edge wins over any accept on that edge, so no pulse is emitted. A key still held after Reset deasserts is treated as a fresh press: full debounce, then one pulse.
- Bounce shorter than DB_CYCLES samples, on press or release, produces no event and no level change.

Test Plan (DB_CYCLES=4):
- Clean press: Run_n low at edge 0, held 20 cycles, Mult_Busy=0 -> Run_Pulse=1 only in the cycle after edge 6; no further pulses while held.
- Bounce: Run_n toggles low/high every 2 cycles for 12 cycles, then stays high -> Run_Pulse never asserts; Run FSM ends in IDLE.
- Busy gating: Mult_Busy=1, clean Run press -> no pulse. Release (stable 10 cycles), Mult_Busy=0, press again -> exactly one pulse.
- Clear latch: Sw_Raw=8'hA5 stable, then Clear_n pressed; Sw_Raw changes to 8'h3C after Clear_Pulse -> Clear_Pulse once, Clear_Level=1 until release debounce, Sw_Latched=8'hA5 held.
- Simultaneous: Run_n and Clear_n fall on the same edge -> Clear_Pulse=1 in the cycle after edge 6, Run_Pulse=0 throughout.
- Reset mid-debounce: Clear_n low at edge 0, Reset=1 on edge 6, released on edge 7 with key still held -> no pulse after edge 6; all outputs 0; Clear_Pulse fires in the cycle after edge 7+DB_CYCLES+2 = 13.
